ysyx_23060221_ifu: RTL
======================

Name: ysyx_23060221_ifu

Overview:
- Instruction fetch unit at the consuming end of the WBU->IFU valid/ready handshake.
- Captures the next PC when WBU_valid & IFU_ready, fetches one 32-bit instruction over an AXI4-Lite read channel, then presents instruction, PC and fault status to the IDU under its own valid/ready handshake.
- Strictly one instruction in flight (multi-cycle, non-pipelined core).

Parameters:
- ADDR_W, 32, fetch address / PC width
- DATA_W, 32, instruction / rdata width

Ports:
- clk  in  1  system clock, all state on posedge
- rst  in  1  synchronous, active-high reset
- pc  in  ADDR_W  next PC from WBU, sampled only on WBU->IFU handshake
- WBU_valid  in  1  WBU offers pc
- IFU_ready  out  1  IFU can accept a new pc
- IFU_valid  out  1  inst/inst_pc/inst_fault valid toward IDU
- IDU_ready  in  1  IDU accepts instruction
- inst  out  DATA_W  fetched instruction
- inst_pc  out  ADDR_W  PC of inst
- inst_fault  out  2  00 none, 01 misaligned PC, 10 bus error (rresp != OKAY)
- araddr  out  ADDR_W  read address
- arvalid  out  1  read address valid
- arready  in  1  slave accepts address
- rdata  in  DATA_W  read data
- rresp  in  2  read response
- rvalid  in  1  read data valid
- rready  out  1  IFU accepts read data

Behaviour:
- Clock and reset: one clock clk; reset rst is synchronous, active-high.
- States: IDLE, AR, R, OUT. Outputs are registered, except that IFU_ready is high exactly in IDLE.
- Reset values: state=IDLE, IFU_ready=1, IFU_valid=0, arvalid=0, rready=0, araddr=0, inst=0, inst_pc=0, inst_fault=00.
- IDLE: on WBU_valid & IFU_ready, latch inst_pc<=pc and araddr<=pc.
  - If pc[1:0]==00: arvalid<=1, go AR.
  - If pc[1:0]!=00: inst<=0, inst_fault<=01, IFU_valid<=1, go OUT. No bus request is issued.
- AR: arvalid held high, araddr stable until arvalid & arready. On handshake: arvalid<=0, rready<=1, go R. arready may already be high in the first AR cycle, giving a 1-cycle AR phase.
- R: rready high. On rvalid & rready: inst<=rdata, inst_fault<=(rresp==00)?00:10, rready<=0, IFU_valid<=1, go OUT.
  - rvalid arriving while in AR is not possible per AXI and is ignored.
- OUT: IFU_valid, inst, inst_pc and inst_fault held stable until IFU_valid & IDU_ready. On handshake: IFU_valid<=0, go IDLE (IFU_ready=1 next cycle).
- Minimum latency with a zero-wait slave: pc handshake at cycle N; arvalid high N+1; arready same cycle; rvalid N+2; IFU_valid N+3.
- A new WBU_valid in any state other than IDLE is not accepted (IFU_ready=0). pc may change freely there.
- Reset in any state returns to IDLE within one cycle and drops arvalid/rready. The memory side is reset by the same rst, so an abandoned transaction is acceptable.
- After reset IFU_ready=1. WBU_valid is also 1 after reset, so the first fetch starts at the first cycle after rst deasserts, using the reset PC.
- No address arithmetic inside the IFU; araddr is exactly the latched pc.

Optional Feature:
- Macro: IFU_PERF_CNT_EN.
- Defined: adds outputs perf_fetch_cnt (64) and perf_fetch_cyc (64), both reset to 0 and wrapping at 2^64.
  - perf_fetch_cnt increments on each IDU handshake.
  - perf_fetch_cyc increments every cycle state is AR or R.
- Undefined: ports and logic absent; functional behaviour otherwise identical.

Decomposition:
- Shared package ysyx_23060221_pkg holds:
  - the IFU state encoding (2 bits)
  - fault codes IFU_FAULT_NONE/MISALIGN/BUSERR
  - AXI response codes RESP_OKAY/EXOKAY/SLVERR/DECERR
  - reset PC constants 0x80000000, and 0x30000000 under SOC
- Natural sub-module: ysyx_23060221_ifu_perf, the counter pair, instantiated only under IFU_PERF_CNT_EN.

Test Plan:
- Zero-wait fetch: rst 2 cycles, pc=0x80000000, WBU_valid=1, arready=1, rvalid one cycle after the AR handshake, rdata=0x00000413, rresp=00 -> araddr=0x80000000; IFU_valid=1 three cycles after the pc handshake with inst=0x00000413, inst_pc=0x80000000, inst_fault=00; IFU_ready=0 until IDU handshake.
- Wait states and backpressure: arready delayed 3 cycles, rvalid delayed 4 cycles, IDU_ready low 5 cycles -> arvalid/araddr held stable throughout; inst held stable for 5 cycles; exactly one AR handshake and one R handshake occur.
- Bus error: pc=0x30000000, rresp=10, rdata=0xDEADBEEF -> inst_fault=10, inst=0xDEADBEEF, IFU_valid=1, normal return to IDLE.
- Misaligned: pc=0x80000002 -> arvalid never asserts; IFU_valid next cycle with inst_fault=01, inst=0, inst_pc=0x80000002.
- Reset mid-transaction: assert rst while in R -> next cycle state IDLE, rready=0, IFU_valid=0, IFU_ready=1; a late rvalid afterwards is ignored.
- IFU_PERF_CNT_EN: 3 back-to-back fetches with 2-cycle memory latency -> perf_fetch_cnt=3, perf_fetch_cyc equals the summed AR+R cycles; a reset clears both counters.

Source files
------------

// File: rtl/ysyx_23060221_pkg.sv
// ysyx_23060221_pkg: shared IFU state encoding, fault/response codes and reset PC.
// Reset PC moves to the SoC flash window when SOC is defined.
package ysyx_23060221_pkg;
   typedef enum logic [1:0] {IFU_IDLE, IFU_AR, IFU_R, IFU_OUT} ifu_state_e;
   localparam logic [1:0] IFU_FAULT_NONE     = 2'b00;
   localparam logic [1:0] IFU_FAULT_MISALIGN = 2'b01;
   localparam logic [1:0] IFU_FAULT_BUSERR   = 2'b10;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;
`ifdef SOC
   localparam logic [31:0] RESET_PC = 32'h3000_0000;
`else
   localparam logic [31:0] RESET_PC = 32'h8000_0000;
`endif
endpackage

// File: rtl/ysyx_23060221_ifu_perf.sv
// ysyx_23060221_ifu_perf: fetch count and fetch-busy cycle counters (wrap at 2^64).
module ysyx_23060221_ifu_perf (
   input  logic        clk,
   input  logic        rst,
   input  logic        fetch_done_i,
   input  logic        busy_i,
   output logic [63:0] perf_fetch_cnt_o,
   output logic [63:0] perf_fetch_cyc_o
);
   logic [63:0] cnt_q, cyc_q;
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         cyc_q <= '0;
      end else begin
         cnt_q <= cnt_q + {63'd0, fetch_done_i};
         cyc_q <= cyc_q + {63'd0, busy_i};
      end
   end
   assign perf_fetch_cnt_o = cnt_q;
   assign perf_fetch_cyc_o = cyc_q;
endmodule

// File: rtl/ysyx_23060221_ifu.sv
// ysyx_23060221_ifu: single-outstanding AXI4-Lite instruction fetch between WBU and IDU.
// IFU_PERF_CNT_EN adds perf_fetch_cnt/perf_fetch_cyc counter outputs.
module ysyx_23060221_ifu
   import ysyx_23060221_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] pc,
   input  logic              WBU_valid,
   output logic              IFU_ready,
   output logic              IFU_valid,
   input  logic              IDU_ready,
   output logic [DATA_W-1:0] inst,
   output logic [ADDR_W-1:0] inst_pc,
   output logic [1:0]        inst_fault,
   output logic [ADDR_W-1:0] araddr,
   output logic              arvalid,
   input  logic              arready,
   input  logic [DATA_W-1:0] rdata,
   input  logic [1:0]        rresp,
   input  logic              rvalid,
   output logic              rready
`ifdef IFU_PERF_CNT_EN
   ,
   output logic [63:0]       perf_fetch_cnt,
   output logic [63:0]       perf_fetch_cyc
`endif
);
   ifu_state_e        state_q;
   logic              ifu_valid_q, arvalid_q, rready_q;
   logic [ADDR_W-1:0] araddr_q, inst_pc_q;
   logic [DATA_W-1:0] inst_q;
   logic [1:0]        inst_fault_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IFU_IDLE;
         ifu_valid_q  <= 1'b0;
         arvalid_q    <= 1'b0;
         rready_q     <= 1'b0;
         araddr_q     <= '0;
         inst_pc_q    <= '0;
         inst_q       <= '0;
         inst_fault_q <= IFU_FAULT_NONE;
      end else begin
         case (state_q)
            IFU_IDLE:
               if (WBU_valid) begin
                  inst_pc_q <= pc;
                  araddr_q  <= pc;
                  if (pc[1:0] == 2'b00) begin
                     arvalid_q <= 1'b1;
                     state_q   <= IFU_AR;
                  end else begin
                     // misaligned PCs never reach the bus
                     inst_q       <= '0;
                     inst_fault_q <= IFU_FAULT_MISALIGN;
                     ifu_valid_q  <= 1'b1;
                     state_q      <= IFU_OUT;
                  end
               end
            IFU_AR:
               if (arready) begin
                  arvalid_q <= 1'b0;
                  rready_q  <= 1'b1;
                  state_q   <= IFU_R;
               end
            IFU_R:
               if (rvalid) begin
                  inst_q       <= rdata;
                  inst_fault_q <= (rresp == RESP_OKAY) ? IFU_FAULT_NONE : IFU_FAULT_BUSERR;
                  rready_q     <= 1'b0;
                  ifu_valid_q  <= 1'b1;
                  state_q      <= IFU_OUT;
               end
            IFU_OUT:
               if (IDU_ready) begin
                  ifu_valid_q <= 1'b0;
                  state_q     <= IFU_IDLE;
               end
            default: state_q <= IFU_IDLE;
         endcase
      end
   end

   assign IFU_ready  = (state_q == IFU_IDLE);
   assign IFU_valid  = ifu_valid_q;
   assign inst       = inst_q;
   assign inst_pc    = inst_pc_q;
   assign inst_fault = inst_fault_q;
   assign araddr     = araddr_q;
   assign arvalid    = arvalid_q;
   assign rready     = rready_q;

`ifdef IFU_PERF_CNT_EN
   ysyx_23060221_ifu_perf u_perf (
      .clk              (clk),
      .rst              (rst),
      .fetch_done_i     (ifu_valid_q & IDU_ready),
      .busy_i           ((state_q == IFU_AR) || (state_q == IFU_R)),
      .perf_fetch_cnt_o (perf_fetch_cnt),
      .perf_fetch_cyc_o (perf_fetch_cyc)
   );
`endif
endmodule
